// File: rtl/rr_mux_arbiter_pkg.sv
// Shared default constants for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/rr_mux_arbiter_mux_n.sv
// Parameterised N:1 data mux built as a binary tree of 2:1 mux cells.
// Level l of the tree is steered by select bit l, so the leaf index is the select value.
module mux_n
   import rr_mux_arbiter_pkg::*;
#(
   parameter  int N     = N_REQ_DEF,
   parameter  int WIDTH = WIDTH_DEF,
   localparam int SEL_W = $clog2(N)
) (
   input  logic [N*WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]   sel_i,
   output logic [WIDTH-1:0]   data_o
);

   // Leaf count is padded up to a power of two; unused leaves carry zero.
   localparam int P = 1 << SEL_W;

   logic [WIDTH-1:0] leaf [P];

   genvar gi;
   generate
      for (gi = 0; gi < P; gi++) begin : g_leaf
         if (gi < N) begin : g_used
            assign leaf[gi] = data_i[gi*WIDTH +: WIDTH];
         end else begin : g_pad
            assign leaf[gi] = '0;
         end
      end
   endgenerate

   // The 2:1 mux cell used at every tree node.
   function automatic logic [WIDTH-1:0] mux2(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             s);
      return s ? b : a;
   endfunction

   // Reduce the leaves level by level; node j of a level merges nodes 2j and 2j+1 below it.
   always_comb begin
      logic [WIDTH-1:0] lvl [P];
      for (int i = 0; i < P; i++) begin
         lvl[i] = leaf[i];
      end
      for (int l = 0; l < SEL_W; l++) begin
         for (int j = 0; j < (P >> (l + 1)); j++) begin
            lvl[j] = mux2(lvl[2*j], lvl[2*j+1], sel_i[l]);
         end
      end
      data_o = lvl[0];
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered output channel between N_REQ requesters.
// The winner index both steers the data mux and becomes out_src.
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter  int N_REQ = N_REQ_DEF,
   parameter  int WIDTH = WIDTH_DEF,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_vld,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_rdy,
   output logic                   out_vld,
   output logic [WIDTH-1:0]       out_data,
   output logic [IDX_W-1:0]       out_src,
   input  logic                   out_rdy
);

   // Index type depends on N_REQ, so it lives here rather than in the package.
   typedef logic [IDX_W-1:0] idx_t;

   idx_t             ptr_q, ptr_d;
   idx_t             winner;
   logic             any_vld;
   logic             can_load;
   logic [WIDTH-1:0] mux_data;

   logic             out_vld_q, out_vld_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   idx_t             out_src_q, out_src_d;

   assign any_vld  = |req_vld;
   assign can_load = !out_vld_q || out_rdy;

   // Scan from ptr upwards with wrap-around; the first valid requester wins.
   always_comb begin
      int   j;
      logic found;
      winner = '0;
      found  = 1'b0;
      for (int off = 0; off < N_REQ; off++) begin
         j = int'(ptr_q) + off;
         if (j >= N_REQ) begin
            j = j - N_REQ;
         end
         if (!found && req_vld[j]) begin
            winner = idx_t'(j);
            found  = 1'b1;
         end
      end
   end

   mux_n #(
      .N     (N_REQ),
      .WIDTH (WIDTH)
   ) u_mux (
      .data_i (req_data),
      .sel_i  (winner),
      .data_o (mux_data)
   );

   // Ready only to the winner, and never while reset is dropping the pending word.
   assign req_rdy = (can_load && any_vld && !rst) ? (N_REQ'(1) << winner) : '0;

   // Next-state: load the winner when the register can take a word, otherwise hold.
   always_comb begin
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      ptr_d      = ptr_q;
      if (can_load) begin
         if (any_vld) begin
            out_vld_d  = 1'b1;
            out_data_d = mux_data;
            out_src_d  = winner;
            ptr_d      = (winner == idx_t'(N_REQ - 1)) ? '0 : winner + idx_t'(1);
         end else begin
            out_vld_d  = 1'b0;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_src_q  <= '0;
         ptr_q      <= '0;
      end else begin
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_src_q  <= out_src_d;
         ptr_q      <= ptr_d;
      end
   end

   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;
   assign out_src  = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed testbench for rr_mux_arbiter (N_REQ=4, WIDTH=8).
module tb_rr_mux_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_vld;
   logic [31:0] req_data;
   logic [3:0]  req_rdy;
   logic        out_vld;
   logic [7:0]  out_data;
   logic [1:0]  out_src;
   logic        out_rdy;

   int checks = 0;
   int errors = 0;

   rr_mux_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_vld  (req_vld),
      .req_data (req_data),
      .req_rdy  (req_rdy),
      .out_vld  (out_vld),
      .out_data (out_data),
      .out_src  (out_src),
      .out_rdy  (out_rdy)
   );

   always #5 clk = ~clk;

   // Each cycle: inputs are set 1 time unit after posedge, req_rdy is checked
   // 1 unit later, outputs are checked 1 unit after the following posedge.

   task automatic check_rdy(input string name, input logic [3:0] exp);
      #1;
      checks++;
      if (req_rdy !== exp) begin
         errors++;
         $display("FAIL %s req_rdy got %b want %b", name, req_rdy, exp);
      end
   endtask

   task automatic check_out(input string name, input logic ev, input logic [7:0] ed, input logic [1:0] es);
      @(posedge clk);
      #1;
      checks++;
      if (out_vld !== ev || out_data !== ed || out_src !== es) begin
         errors++;
         $display("FAIL %s out vld/data/src got %b/%h/%0d want %b/%h/%0d",
                  name, out_vld, out_data, out_src, ev, ed, es);
      end else begin
         $display("txn %s vld=%b data=%h src=%0d", name, out_vld, out_data, out_src);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_vld = 4'hF; out_rdy = 1'b1;
      for (int k = 0; k < 2; k++) begin
         check_rdy("reset_rdy", 4'b0000);
         check_out("reset_out", 1'b0, 8'h00, 2'd0);
      end
      rst = 1'b0;
   endtask

   task automatic test_rotation();
      logic [1:0] exp_src [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [7:0] exp_dat [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
      req_vld = 4'hF; out_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check_rdy("rotation_rdy", exp_rdy[k]);
         check_out("rotation_out", 1'b1, exp_dat[k], exp_src[k]);
      end
   endtask

   task automatic test_skip_idle();
      logic [1:0] exp_src [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
      logic [3:0] exp_rdy [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
      logic [7:0] exp_dat [4] = '{8'hA1, 8'hA3, 8'hA1, 8'hA3};
      // Bring ptr back to 0 first.
      rst = 1'b1; req_vld = 4'h0; out_rdy = 1'b1;
      check_out("skip_prereset", 1'b0, 8'h00, 2'd0);
      rst = 1'b0; req_vld = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         check_rdy("skip_rdy", exp_rdy[k]);
         check_out("skip_out", 1'b1, exp_dat[k], exp_src[k]);
      end
   endtask

   task automatic test_backpressure();
      // ptr=0; load requester 2 alone so ptr becomes 3.
      req_vld = 4'b0100; out_rdy = 1'b1;
      check_rdy("bp_load_rdy", 4'b0100);
      check_out("bp_load_out", 1'b1, 8'hA2, 2'd2);
      req_vld = 4'hF; out_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_rdy("bp_stall_rdy", 4'b0000);
         check_out("bp_stall_out", 1'b1, 8'hA2, 2'd2);
      end
      out_rdy = 1'b1;
      check_rdy("bp_release_rdy", 4'b1000);
      check_out("bp_release_out", 1'b1, 8'hA3, 2'd3);
   endtask

   task automatic test_wrap();
      // Last grant was 3, so ptr is 0: requester 0 wins, then ptr=1 gives 3.
      req_vld = 4'b1001; out_rdy = 1'b1;
      check_rdy("wrap_rdy0", 4'b0001);
      check_out("wrap_out0", 1'b1, 8'hA0, 2'd0);
      check_rdy("wrap_rdy1", 4'b1000);
      check_out("wrap_out1", 1'b1, 8'hA3, 2'd3);
   endtask

   task automatic test_idle();
      req_vld = 4'h0; out_rdy = 1'b1;
      check_rdy("idle_rdy", 4'b0000);
      check_out("idle_out", 1'b0, 8'hA3, 2'd3);
   endtask

   task automatic test_midop_reset();
      // Load requester 1 so ptr becomes 2, then stall it.
      req_vld = 4'b0010; out_rdy = 1'b1;
      check_rdy("mid_load_rdy", 4'b0010);
      check_out("mid_load_out", 1'b1, 8'hA1, 2'd1);
      req_vld = 4'hF; out_rdy = 1'b0;
      check_rdy("mid_stall_rdy", 4'b0000);
      check_out("mid_stall_out", 1'b1, 8'hA1, 2'd1);
      rst = 1'b1; out_rdy = 1'b1;
      check_rdy("mid_rst_rdy", 4'b0000);
      check_out("mid_rst_out", 1'b0, 8'h00, 2'd0);
      // ptr must be 0 again: with 1 and 2 valid, requester 1 wins.
      rst = 1'b0; req_vld = 4'b0110;
      check_rdy("mid_after_rdy", 4'b0010);
      check_out("mid_after_out", 1'b1, 8'hA1, 2'd1);
   endtask

   initial begin
      rst      = 1'b1;
      req_vld  = 4'h0;
      out_rdy  = 1'b0;
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      @(posedge clk);
      #1;
      test_reset();
      test_rotation();
      test_skip_idle();
      test_backpressure();
      test_wrap();
      test_idle();
      test_midop_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
